wb_trace_capture: RTL

//   Sits between the CPU debug write-back port and the trace comparator. It

---
 rtl/wb_trace_capture.sv | 103 ++++++++++
 1 files changed

// File: rtl/wb_trace_capture.sv
// wb_trace_capture: filters and masks CPU write-back events, drops
// unchanged writes, and buffers survivors in a valid/ready FIFO.
module wb_trace_capture #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     trace_en,
  input  logic [PC_W-1:0]          debug_wb_pc,
  input  logic [7:0]               debug_wb_rf_wen,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [DATA_W-1:0]        debug_wb_rf_wdata,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [PC_W-1:0]          trc_pc,
  output logic [4:0]               trc_wnum,
  output logic [DATA_W-1:0]        trc_wdata,
  output logic [$clog2(DEPTH):0]   trc_level,
  output logic [31:0]              trc_count,
  output logic                     trc_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] v;
  logic [DATA_W-1:0] shadow [32];

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [4:0]        mem_wnum [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level;

  logic q;
  logic full;
  logic pop;
  logic accept;

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_mask
    assign v[8*i +: 8] = debug_wb_rf_wdata[8*i +: 8]
                       & {8{debug_wb_rf_wen[i]}};
  end

  // Shadow compare uses the pre-update value of this cycle
  always_comb begin
    q      = trace_en
           & (|debug_wb_rf_wen)
           & (debug_wb_rf_wnum != 5'd0)
           & (shadow[debug_wb_rf_wnum] != v);
    full   = (level == FULL_LVL);
    pop    = trc_valid & trc_ready;
    accept = q & (~full | pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else if (q) begin
      shadow[debug_wb_rf_wnum] <= v;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && accept) begin
      mem_pc[wptr]   <= debug_wb_pc;
      mem_wnum[wptr] <= debug_wb_rf_wnum;
      mem_data[wptr] <= v;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      trc_count    <= '0;
      trc_overflow <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop)    rptr <= rptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (accept)     trc_count    <= trc_count + 32'd1;
      if (q & ~accept) trc_overflow <= 1'b1;
    end
  end

  assign trc_valid = (level != '0);
  assign trc_level = level;
  assign trc_pc    = trc_valid ? mem_pc[rptr]   : '0;
  assign trc_wnum  = trc_valid ? mem_wnum[rptr] : '0;
  assign trc_wdata = trc_valid ? mem_data[rptr] : '0;

endmodule
